// File: rtl/slave_rx_packet_mep_if.sv
// Bus between the SIE receive side, the endpoint RX FIFOs and the packet
// processor; the slave modport is the processor's view.
interface slave_rx_packet_mep_if #(
  parameter int NUM_EP   = 4,
  parameter int EP_SEL_W = 2,
  parameter int CNT_W    = 7
);
  logic                getPacketEn;
  logic [EP_SEL_W-1:0] epSel;
  logic [7:0]          RXDataIn;
  logic                RXDataValid;
  logic [7:0]          RXStreamStatusIn;
  logic [NUM_EP-1:0]   RXFifoFull;
  logic [NUM_EP-1:0]   RXFifoWEn;
  logic [7:0]          RXFifoData;
  logic [3:0]          RxPID;
  logic                RXPacketRdy;
  logic                CRCError;
  logic                bitStuffError;
  logic                dataSequence;
  logic                ACKRxed;
  logic                RXOverflow;
  logic                RXTimeOut;
  logic                maxSizeErr;
  logic [CNT_W-1:0]    byteCount;

  modport slave (
    input  getPacketEn, epSel, RXDataIn, RXDataValid, RXStreamStatusIn, RXFifoFull,
    output RXFifoWEn, RXFifoData, RxPID, RXPacketRdy, CRCError, bitStuffError,
           dataSequence, ACKRxed, RXOverflow, RXTimeOut, maxSizeErr, byteCount
  );

  modport master (
    output getPacketEn, epSel, RXDataIn, RXDataValid, RXStreamStatusIn, RXFifoFull,
    input  RXFifoWEn, RXFifoData, RxPID, RXPacketRdy, CRCError, bitStuffError,
           dataSequence, ACKRxed, RXOverflow, RXTimeOut, maxSizeErr, byteCount
  );
endinterface

// File: rtl/slave_rx_packet_mep.sv
// Slave USB receive packet processor: decodes the PID, captures handshake/EOP
// status, holds back trailing CRC bytes and steers payload to one of NUM_EP FIFOs.
`ifndef RX_PACKET_START
`define RX_PACKET_START 8'h00
`endif
`ifndef RX_PACKET_STREAM
`define RX_PACKET_STREAM 8'h01
`endif
`ifndef CRC_ERROR_BIT
`define CRC_ERROR_BIT 0
`endif
`ifndef BIT_STUFF_ERROR_BIT
`define BIT_STUFF_ERROR_BIT 1
`endif
`ifndef RX_OVERFLOW_BIT
`define RX_OVERFLOW_BIT 2
`endif
`ifndef ACK_RXED_BIT
`define ACK_RXED_BIT 5
`endif
`ifndef DATA_SEQUENCE_BIT
`define DATA_SEQUENCE_BIT 6
`endif
`ifndef HANDSHAKE
`define HANDSHAKE 2'h2
`endif
`ifndef DATA
`define DATA 2'h3
`endif

module slave_rx_packet_mep #(
  parameter int NUM_EP      = 4,
  parameter int EP_SEL_W    = 2,
  parameter int TRAIL_BYTES = 2,
  parameter int MAX_PKT     = 64,
  parameter int CNT_W       = 7
) (
  input logic clk,
  input logic rst,
  slave_rx_packet_mep_if.slave bus
);
  localparam int HC_W = $clog2(TRAIL_BYTES + 1);

  typedef enum logic [2:0] {WAIT_EN, WAIT_PKT, CHK_PID, HS, DATA, FIN, PKT_RDY} state_t;

  state_t              state, next_state;
  logic [EP_SEL_W-1:0] ep_reg;
  logic [7:0]          hold [TRAIL_BYTES];
  logic [HC_W-1:0]     hold_cnt;
  logic [7:0]          status_reg;
  logic [3:0]          pid;
  logic [CNT_W-1:0]    byte_count;
  logic [NUM_EP-1:0]   fifo_wen;
  logic [7:0]          fifo_data;
  logic                crc_err, stuff_err, data_seq, ack_rxed, overflow, timeout, max_err;
  logic [2**EP_SEL_W-1:0] full_pad;
  logic                stream_byte, pop, under_max;

  // Unpopulated endpoint slots look permanently full, so bytes aimed there are dropped.
  always_comb begin
    full_pad = '1;
    full_pad[NUM_EP-1:0] = bus.RXFifoFull;
  end

  assign stream_byte = (state == DATA) && bus.RXDataValid &&
                       (bus.RXStreamStatusIn == `RX_PACKET_STREAM);
  assign pop         = stream_byte && (hold_cnt == HC_W'(TRAIL_BYTES));
  assign under_max   = byte_count < CNT_W'(MAX_PKT);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_EN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_EN:  if (bus.getPacketEn) next_state = WAIT_PKT;
      WAIT_PKT: if (bus.RXDataValid)
                  next_state = (bus.RXStreamStatusIn == `RX_PACKET_START) ? CHK_PID : PKT_RDY;
      CHK_PID:  begin
        if (pid[1:0] == `HANDSHAKE)  next_state = HS;
        else if (pid[1:0] == `DATA)  next_state = DATA;
        else                         next_state = PKT_RDY;
      end
      HS:       if (bus.RXDataValid) next_state = PKT_RDY;
      DATA:     if (bus.RXDataValid && !stream_byte) next_state = FIN;
      FIN:      next_state = PKT_RDY;
      PKT_RDY:  next_state = WAIT_EN;
      default:  next_state = WAIT_EN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ep_reg     <= '0;
      hold_cnt   <= '0;
      status_reg <= '0;
      pid        <= '0;
      byte_count <= '0;
      fifo_wen   <= '0;
      fifo_data  <= '0;
      crc_err    <= 1'b0;
      stuff_err  <= 1'b0;
      data_seq   <= 1'b0;
      ack_rxed   <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      max_err    <= 1'b0;
      for (int i = 0; i < TRAIL_BYTES; i++) hold[i] <= '0;
    end else begin
      fifo_wen <= '0;
      case (state)
        WAIT_EN: if (bus.getPacketEn) ep_reg <= bus.epSel;
        WAIT_PKT: begin
          hold_cnt   <= '0;
          byte_count <= '0;
          crc_err    <= 1'b0;
          stuff_err  <= 1'b0;
          data_seq   <= 1'b0;
          ack_rxed   <= 1'b0;
          overflow   <= 1'b0;
          timeout    <= 1'b0;
          max_err    <= 1'b0;
          if (bus.RXDataValid) begin
            if (bus.RXStreamStatusIn == `RX_PACKET_START) pid <= bus.RXDataIn[3:0];
            else                                          timeout <= 1'b1;
          end
        end
        HS: if (bus.RXDataValid) begin
          overflow <= bus.RXDataIn[`RX_OVERFLOW_BIT];
          ack_rxed <= bus.RXDataIn[`ACK_RXED_BIT];
        end
        DATA: if (bus.RXDataValid) begin
          if (stream_byte) begin
            for (int i = TRAIL_BYTES - 1; i > 0; i--) hold[i] <= hold[i-1];
            hold[0] <= bus.RXDataIn;
            if (!pop) hold_cnt <= hold_cnt + 1'b1;
            // The oldest held byte is now known not to be CRC, so it is payload.
            if (pop) begin
              if (byte_count != '1) byte_count <= byte_count + 1'b1;
              if (!under_max) begin
                max_err <= 1'b1;
              end else if (full_pad[ep_reg]) begin
                overflow <= 1'b1;
              end else begin
                fifo_wen  <= NUM_EP'(1) << ep_reg;
                fifo_data <= hold[TRAIL_BYTES-1];
              end
            end
          end else begin
            status_reg <= bus.RXStreamStatusIn;
          end
        end
        FIN: begin
          crc_err   <= status_reg[`CRC_ERROR_BIT];
          stuff_err <= status_reg[`BIT_STUFF_ERROR_BIT];
          data_seq  <= status_reg[`DATA_SEQUENCE_BIT];
        end
        default: ;
      endcase
    end
  end

  assign bus.RXFifoWEn     = fifo_wen;
  assign bus.RXFifoData    = fifo_data;
  assign bus.RxPID         = pid;
  assign bus.RXPacketRdy   = (state == PKT_RDY);
  assign bus.CRCError      = crc_err;
  assign bus.bitStuffError = stuff_err;
  assign bus.dataSequence  = data_seq;
  assign bus.ACKRxed       = ack_rxed;
  assign bus.RXOverflow    = overflow;
  assign bus.RXTimeOut     = timeout;
  assign bus.maxSizeErr    = max_err;
  assign bus.byteCount     = byte_count;
endmodule

// File: tb/tb_slave_rx_packet_mep.sv
// Directed bench for slave_rx_packet_mep: hand-computed packets, write log
// captured from the FIFO strobes, immediate-assertion checks.
module tb_slave_rx_packet_mep;
  localparam logic [7:0] ST_START  = 8'h00;
  localparam logic [7:0] ST_STREAM = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_pulses = 0;
  int   wr_ep [$];
  logic [7:0] wr_data [$];

  slave_rx_packet_mep_if #(.NUM_EP(4), .EP_SEL_W(2), .CNT_W(7)) bus ();

  slave_rx_packet_mep #(.NUM_EP(4), .EP_SEL_W(2), .TRAIL_BYTES(2), .MAX_PKT(64), .CNT_W(7))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every FIFO strobe and confirm it is one-hot.
  always @(negedge clk) begin
    if (bus.RXPacketRdy) rdy_pulses++;
    if (bus.RXFifoWEn != '0) begin
      chk("wen_onehot", 32'($onehot(bus.RXFifoWEn)), 32'd1);
      for (int i = 0; i < 4; i++)
        if (bus.RXFifoWEn[i]) wr_ep.push_back(i);
      wr_data.push_back(bus.RXFifoData);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic startPacket(input logic [1:0] ep);
    wr_ep.delete();
    wr_data.delete();
    rdy_pulses = 0;
    bus.getPacketEn = 1'b1;
    bus.epSel = ep;
    @(negedge clk);
    bus.getPacketEn = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic [7:0] s);
    bus.RXDataIn = d;
    bus.RXStreamStatusIn = s;
    bus.RXDataValid = 1'b1;
    @(negedge clk);
    bus.RXDataValid = 1'b0;
  endtask

  task automatic sendPid(input logic [7:0] p);
    sendByte(p, ST_START);
    @(negedge clk);
  endtask

  task automatic waitRdy(input string tag);
    int n = 0;
    while (!bus.RXPacketRdy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(bus.RXPacketRdy), 32'd1);
    @(negedge clk);
    chk({tag, "_rdy_once"}, 32'(bus.RXPacketRdy), 32'd0);
    chk({tag, "_rdy_pulses"}, 32'(rdy_pulses), 32'd1);
  endtask

  function automatic logic [6:0] flags();
    return {bus.CRCError, bus.bitStuffError, bus.dataSequence, bus.ACKRxed,
            bus.RXOverflow, bus.RXTimeOut, bus.maxSizeErr};
  endfunction

  initial begin
    bus.getPacketEn = 1'b0;
    bus.epSel = '0;
    bus.RXDataIn = '0;
    bus.RXDataValid = 1'b0;
    bus.RXStreamStatusIn = '0;
    bus.RXFifoFull = '0;
    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(bus.RXFifoWEn), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    chk("rst_count", 32'(bus.byteCount), 32'd0);
    chk("rst_rdy", 32'(bus.RXPacketRdy), 32'd0);
    chk("rst_pid", 32'(bus.RxPID), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DATA0 to endpoint 2: five stream bytes, the last two are CRC.
    startPacket(2'd2);
    sendPid(8'hC3);
    sendByte(8'h11, ST_STREAM);
    sendByte(8'h22, ST_STREAM);
    sendByte(8'h33, ST_STREAM);
    sendByte(8'h44, ST_STREAM);
    sendByte(8'h55, ST_STREAM);
    sendByte(8'h00, 8'h00);
    waitRdy("t1");
    chk("t1_nwr", 32'(wr_data.size()), 32'd3);
    if (wr_data.size() == 3) begin
      chk("t1_d0", 32'(wr_data[0]), 32'h11);
      chk("t1_d1", 32'(wr_data[1]), 32'h22);
      chk("t1_d2", 32'(wr_data[2]), 32'h33);
      chk("t1_ep", 32'(wr_ep[2]), 32'd2);
    end
    chk("t1_count", 32'(bus.byteCount), 32'd3);
    chk("t1_flags", 32'(flags()), 32'd0);
    chk("t1_pid", 32'(bus.RxPID), 32'h3);

    // Short packet: only CRC bytes, EOP reports CRC and bit-stuff errors.
    startPacket(2'd1);
    sendPid(8'hC3);
    sendByte(8'hAA, ST_STREAM);
    sendByte(8'hBB, ST_STREAM);
    sendByte(8'h00, 8'h03);
    waitRdy("short");
    chk("short_nwr", 32'(wr_data.size()), 32'd0);
    chk("short_count", 32'(bus.byteCount), 32'd0);
    chk("short_flags", 32'(flags()), 32'b1100000);

    // 66 payload + 2 CRC back to back; only 64 fit.
    startPacket(2'd0);
    sendPid(8'hC3);
    for (int i = 0; i < 68; i++) sendByte(8'(i), ST_STREAM);
    sendByte(8'h00, 8'h40);
    waitRdy("t2");
    chk("t2_nwr", 32'(wr_data.size()), 32'd64);
    if (wr_data.size() == 64) begin
      chk("t2_first", 32'(wr_data[0]), 32'h00);
      chk("t2_last", 32'(wr_data[63]), 32'h3F);
      chk("t2_ep", 32'(wr_ep[63]), 32'd0);
    end
    chk("t2_count", 32'(bus.byteCount), 32'd66);
    chk("t2_flags", 32'(flags()), 32'b0010001);

    // Endpoint 1 fills after two writes.
    startPacket(2'd1);
    sendPid(8'hC3);
    for (int i = 0; i < 4; i++) sendByte(8'hA0 + 8'(i), ST_STREAM);
    bus.RXFifoFull = 4'b0010;
    for (int i = 4; i < 8; i++) sendByte(8'hA0 + 8'(i), ST_STREAM);
    sendByte(8'h00, 8'h00);
    waitRdy("t3");
    bus.RXFifoFull = '0;
    chk("t3_nwr", 32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) chk("t3_d1", 32'(wr_data[1]), 32'hA1);
    chk("t3_count", 32'(bus.byteCount), 32'd6);
    chk("t3_flags", 32'(flags()), 32'b0000100);

    // ACK handshake.
    startPacket(2'd0);
    sendPid(8'hD2);
    sendByte(8'h20, 8'h00);
    waitRdy("t4");
    chk("t4_nwr", 32'(wr_data.size()), 32'd0);
    chk("t4_flags", 32'(flags()), 32'b0001000);
    chk("t4_pid", 32'(bus.RxPID), 32'h2);

    // First byte is not a packet start.
    startPacket(2'd0);
    sendByte(8'h5A, ST_STREAM);
    waitRdy("t5");
    chk("t5_nwr", 32'(wr_data.size()), 32'd0);
    chk("t5_flags", 32'(flags()), 32'b0000010);

    // Reset mid-payload, then a clean packet.
    startPacket(2'd3);
    sendPid(8'hC3);
    sendByte(8'h11, ST_STREAM);
    sendByte(8'h22, ST_STREAM);
    sendByte(8'h33, ST_STREAM);
    sendByte(8'h44, ST_STREAM);
    rst = 1'b1;
    bus.RXDataIn = 8'h55;
    bus.RXStreamStatusIn = ST_STREAM;
    bus.RXDataValid = 1'b1;
    @(negedge clk);
    chk("t6_wen", 32'(bus.RXFifoWEn), 32'd0);
    chk("t6_count", 32'(bus.byteCount), 32'd0);
    chk("t6_pid", 32'(bus.RxPID), 32'd0);
    chk("t6_flags", 32'(flags()), 32'd0);
    chk("t6_nwr", 32'(wr_data.size()), 32'd2);
    rst = 1'b0;
    bus.RXDataValid = 1'b0;
    @(negedge clk);
    chk("t6_nwr_after", 32'(wr_data.size()), 32'd2);
    startPacket(2'd3);
    sendPid(8'hC3);
    sendByte(8'h01, ST_STREAM);
    sendByte(8'h02, ST_STREAM);
    sendByte(8'h03, ST_STREAM);
    sendByte(8'h00, 8'h00);
    waitRdy("t6b");
    chk("t6b_nwr", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() == 1) begin
      chk("t6b_d0", 32'(wr_data[0]), 32'h01);
      chk("t6b_ep", 32'(wr_ep[0]), 32'd3);
    end
    chk("t6b_count", 32'(bus.byteCount), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
